// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, constants and the prefetch queue entry type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic filled;
  } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_unit_fetch_queue.sv
// fetch_queue: circular prefetch buffer with in-order allocate, fill and pop plus a flush
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [XLEN-1:0] i_fill_instr,
  input  logic            i_pop,
  output logic            o_head_valid,
  output logic [XLEN-1:0] o_head_pc,
  output logic [XLEN-1:0] o_head_instr,
  output logic [CW-1:0]   o_count,
  output logic [CW-1:0]   o_pending
);
  fetch_entry_t r_q [QDEPTH];
  logic [PW-1:0] r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [CW-1:0] r_count, r_pending;

  assign o_head_valid = (r_count != '0) && r_q[r_head_ptr].filled;
  assign o_head_pc    = r_q[r_head_ptr].pc;
  assign o_head_instr = r_q[r_head_ptr].instr;
  assign o_count      = r_count;
  assign o_pending    = r_pending;

  // entry storage, pointers and occupancy; flush drops everything but keeps stale data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < QDEPTH; i++) r_q[i].filled <= 1'b0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
    end else begin
      if (i_alloc) begin
        r_q[r_alloc_ptr].pc     <= i_alloc_pc;
        r_q[r_alloc_ptr].filled <= 1'b0;
        r_alloc_ptr             <= r_alloc_ptr + 1'b1;
      end
      if (i_fill) begin
        r_q[r_fill_ptr].instr  <= i_fill_instr;
        r_q[r_fill_ptr].filled <= 1'b1;
        r_fill_ptr             <= r_fill_ptr + 1'b1;
      end
      if (i_pop) r_head_ptr <= r_head_ptr + 1'b1;
      r_count   <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_pending <= r_pending + CW'(i_alloc) - CW'(i_fill);
    end
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: in-order instruction fetch with prefetch queue; IF_PREFETCH_PERF_EN adds perf counters
module if_prefetch_unit #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_pipe_valid,
  output logic [XLEN-1:0] o_pipe_PC,
  output logic [XLEN-1:0] o_pipe_Instruction,
  input  logic            i_pipe_stall
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_killed
`endif
);
  import cpu_pkg::*;
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_kill_cnt;
  logic [CW-1:0]   w_count, w_pending, w_kill_next;
  logic            w_alloc, w_fill, w_kill, w_pop, w_absorb, w_head_valid;
  logic            w_unused;

  assign w_unused     = ^i_redirect_pc[1:0];
  assign o_imem_req   = !reset && !i_redirect_valid && (w_count < CW'(QDEPTH));
  assign o_imem_addr  = r_pc;
  assign w_alloc      = o_imem_req && i_imem_gnt;
  assign w_kill       = i_imem_rvalid && (r_kill_cnt != '0);
  assign w_fill       = i_imem_rvalid && !w_kill && (w_pending != '0) && !i_redirect_valid;
  assign w_pop        = w_head_valid && !i_pipe_stall && !i_redirect_valid;
  assign w_absorb     = i_imem_rvalid && ((r_kill_cnt != '0) || (w_pending != '0));
  assign w_kill_next  = i_redirect_valid ? r_kill_cnt + w_pending - CW'(w_absorb)
                                         : r_kill_cnt - CW'(w_kill);
  assign o_pipe_valid = w_head_valid;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (i_redirect_valid),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_instr (i_imem_rdata),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_pc    (o_pipe_PC),
    .o_head_instr (o_pipe_Instruction),
    .o_count      (w_count),
    .o_pending    (w_pending)
  );

  // next fetch address and count of stale responses still owed by memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_kill_cnt <= '0;
    end else begin
      r_pc       <= i_redirect_valid ? {i_redirect_pc[XLEN-1:2], 2'b00} : w_alloc ? r_pc + XLEN'(4) : r_pc;
      r_kill_cnt <= w_kill_next;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_killed;
  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_killed  = r_perf_killed;
  // delivered instructions, and responses or entries thrown away
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_killed  <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_pop);
      r_perf_killed  <= r_perf_killed + 32'(w_kill) + (i_redirect_valid ? 32'(w_count) : 32'd0);
    end
  end
`endif
endmodule
